// File: rtl/axis_mem_word_packer_pkg.sv
// rtl/axis_mem_word_packer_pkg.sv - shared state type, width helpers and destination decode
package axis_mem_word_packer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HDR   = 2'd1,
    DATA  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Upper bound on physical ports the decode helper understands.
  localparam int MAX_PORTS  = 32;
  localparam int MAX_QUEUES = MAX_PORTS + 1;
  localparam int DST_MAX_W  = 2 * MAX_PORTS;

  function automatic int bytes_of(input int bits);
    return bits / 8;
  endfunction

  function automatic int clog2_w(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

  // Even destination bits select physical ports; any odd bit selects the CPU queue.
  function automatic logic [MAX_QUEUES-1:0] dst_decode(
    input logic [DST_MAX_W-1:0] dst,
    input int                   num_ports,
    input int                   cpu_queue
  );
    logic [MAX_QUEUES-1:0] q;
    q = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (i < num_ports) begin
        q[i]         = q[i] | dst[2*i];
        q[cpu_queue] = q[cpu_queue] | dst[2*i+1];
      end
    end
    return q;
  endfunction

endpackage

// File: rtl/axis_keep_popcount.sv
// rtl/axis_keep_popcount.sv - counts the enabled bytes of a contiguous tkeep vector
module axis_keep_popcount #(
  parameter int KEEP_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic [KEEP_W-1:0] keep,
  output logic [CNT_W-1:0]  count
);

  // Sum of set keep bits equals the byte count for an LSB-aligned run.
  always_comb begin
    count = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      count = count + CNT_W'(keep[i]);
    end
  end

endmodule

// File: rtl/axis_mem_word_packer.sv
// rtl/axis_mem_word_packer.sv - repacks AXIS beats into header plus byte-packed memory words
module axis_mem_word_packer
  import axis_mem_word_packer_pkg::*;
#(
  parameter int AXIS_DATA_W = 256,
  parameter int AXIS_USER_W = 128,
  parameter int MEM_DATA_W  = 192,
  parameter int NUM_PORTS   = 4,
  parameter int NUM_QUEUES  = NUM_PORTS + 1,
  parameter int DST_POS     = 24
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               s_tvalid,
  output logic                               s_tready,
  input  logic [AXIS_DATA_W-1:0]             s_tdata,
  input  logic [AXIS_DATA_W/8-1:0]           s_tkeep,
  input  logic [AXIS_USER_W-1:0]             s_tuser,
  input  logic                               s_tlast,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [MEM_DATA_W-1:0]              m_data,
  output logic                               m_hdr,
  output logic                               m_last,
  output logic [$clog2(MEM_DATA_W/8+1)-1:0]  m_bytes,
  output logic [NUM_QUEUES-1:0]              m_queue
);

  localparam int AB      = bytes_of(AXIS_DATA_W);
  localparam int MB      = bytes_of(MEM_DATA_W);
  localparam int ACC_B   = AB + MB;
  localparam int CNT_W   = clog2_w(ACC_B + 1);
  localparam int BYTES_W = $clog2(MB + 1);
  localparam int KCNT_W  = clog2_w(AB + 1);

  localparam logic [CNT_W-1:0]   MB_CNT   = CNT_W'(MB);
  localparam logic [BYTES_W-1:0] MB_BYTES = BYTES_W'(MB);

  state_t                   state, state_n;
  logic [ACC_B*8-1:0]       acc, acc_n, acc_shift, beat_ext;
  logic [AB*8-1:0]          keep_mask;
  logic [CNT_W-1:0]         acc_bytes, acc_bytes_n, acc_base;
  logic [KCNT_W-1:0]        keep_cnt;
  logic [AXIS_USER_W-1:0]   user_q, user_n;
  logic [NUM_QUEUES-1:0]    queue_n, queue_dec;
  logic [AB-1:0]            keep_inc;
  logic                     pop, accept;

  logic                     s_tready_n, m_valid_n, m_hdr_n, m_last_n;
  logic [BYTES_W-1:0]       m_bytes_n;
  logic [MEM_DATA_W-1:0]    m_data_n;

  assign pop    = m_valid & m_ready;
  assign accept = s_tvalid & s_tready;

  axis_keep_popcount #(
    .KEEP_W (AB),
    .CNT_W  (KCNT_W)
  ) u_keep_popcount (
    .keep  (s_tkeep),
    .count (keep_cnt)
  );

  assign queue_dec = NUM_QUEUES'(dst_decode(DST_MAX_W'(s_tuser[DST_POS +: 2*NUM_PORTS]),
                                            NUM_PORTS, NUM_QUEUES - 1));

  // Byte-enable expansion so bytes outside tkeep never enter the accumulator.
  always_comb begin
    keep_mask = '0;
    for (int i = 0; i < AB; i++) begin
      keep_mask[i*8 +: 8] = {8{s_tkeep[i]}};
    end
  end

  assign beat_ext  = (ACC_B*8)'(s_tdata & keep_mask);
  assign acc_shift = pop ? (acc >> (MB*8)) : acc;
  assign acc_base  = pop ? (acc_bytes - MB_CNT) : acc_bytes;

  // Next-state: header latch, accumulator pop/append, drain to the last word.
  always_comb begin
    state_n     = state;
    acc_n       = acc;
    acc_bytes_n = acc_bytes;
    user_n      = user_q;
    queue_n     = m_queue;
    case (state)
      IDLE: begin
        if (s_tvalid) begin
          user_n  = s_tuser;
          queue_n = queue_dec;
          state_n = HDR;
        end
      end
      HDR: begin
        if (m_ready) state_n = DATA;
      end
      DATA: begin
        acc_n       = acc_shift;
        acc_bytes_n = acc_base;
        if (accept) begin
          acc_n       = acc_shift | (beat_ext << {acc_base, 3'b000});
          acc_bytes_n = acc_base + CNT_W'(keep_cnt);
          if (s_tlast) state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (pop) begin
          if (m_last) begin
            state_n     = IDLE;
            acc_n       = '0;
            acc_bytes_n = '0;
          end else begin
            acc_n       = acc_shift;
            acc_bytes_n = acc_base;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output values for the upcoming cycle, decoded from the next state.
  always_comb begin
    s_tready_n = 1'b0;
    m_valid_n  = 1'b0;
    m_hdr_n    = 1'b0;
    m_last_n   = 1'b0;
    m_bytes_n  = '0;
    m_data_n   = '0;
    case (state_n)
      HDR: begin
        m_valid_n = 1'b1;
        m_hdr_n   = 1'b1;
        m_bytes_n = MB_BYTES;
        m_data_n  = MEM_DATA_W'(user_n);
      end
      DATA: begin
        s_tready_n = (acc_bytes_n <= MB_CNT);
        m_valid_n  = (acc_bytes_n >= MB_CNT);
        m_bytes_n  = MB_BYTES;
        m_data_n   = acc_n[MEM_DATA_W-1:0];
      end
      DRAIN: begin
        m_valid_n = 1'b1;
        m_last_n  = (acc_bytes_n <= MB_CNT);
        m_bytes_n = m_last_n ? acc_bytes_n[BYTES_W-1:0] : MB_BYTES;
        m_data_n  = acc_n[MEM_DATA_W-1:0];
      end
      default: ;
    endcase
  end

  // State, accumulator and registered outputs; reset drops any buffered packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      acc_bytes <= '0;
      user_q    <= '0;
      s_tready  <= 1'b0;
      m_valid   <= 1'b0;
      m_hdr     <= 1'b0;
      m_last    <= 1'b0;
      m_bytes   <= '0;
      m_data    <= '0;
      m_queue   <= '0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      acc_bytes <= acc_bytes_n;
      user_q    <= user_n;
      s_tready  <= s_tready_n;
      m_valid   <= m_valid_n;
      m_hdr     <= m_hdr_n;
      m_last    <= m_last_n;
      m_bytes   <= m_bytes_n;
      m_data    <= m_data_n;
      m_queue   <= queue_n;
    end
  end

  // Accepted beats must carry tkeep as a run of ones starting at byte 0.
  assign keep_inc = s_tkeep + AB'(1);
  keep_contiguous: assert property (@(posedge clk) disable iff (reset)
    (s_tvalid && s_tready) |-> ((s_tkeep & keep_inc) == '0));

endmodule

// File: tb/tb_axis_mem_word_packer.sv
// tb/tb_axis_mem_word_packer.sv - directed self-checking bench for axis_mem_word_packer
module tb_axis_mem_word_packer;

  localparam int AB = 32;
  localparam int MB = 24;

  typedef struct {
    logic [255:0] data;
    logic [31:0]  keep;
    logic [127:0] user;
    logic         last;
  } beat_t;

  typedef struct {
    logic [191:0] data;
    logic         hdr;
    logic         last;
    logic [4:0]   bytes;
    logic [4:0]   queue;
    int           cyc;
  } word_t;

  logic         clk;
  logic         reset;
  logic         s_tvalid;
  logic         s_tready;
  logic [255:0] s_tdata;
  logic [31:0]  s_tkeep;
  logic [127:0] s_tuser;
  logic         s_tlast;
  logic         m_valid;
  logic         m_ready;
  logic [191:0] m_data;
  logic         m_hdr;
  logic         m_last;
  logic [4:0]   m_bytes;
  logic [4:0]   m_queue;

  beat_t src[$];
  word_t got[$];
  int    cyc, in_cnt, n_checks, n_pass, stalls;
  bit    ready_toggle, tog, stall_prev;
  logic [191:0] sv_data;
  logic [4:0]   sv_bytes;
  logic         sv_hdr, sv_last;

  axis_mem_word_packer dut (
    .clk      (clk),
    .reset    (reset),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
    .s_tkeep  (s_tkeep),
    .s_tuser  (s_tuser),
    .s_tlast  (s_tlast),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_hdr    (m_hdr),
    .m_last   (m_last),
    .m_bytes  (m_bytes),
    .m_queue  (m_queue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] actual, input logic [255:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, actual, expected);
  endtask

  task automatic send_pkt(input logic [127:0] user, input int n, input int base);
    int nbeats;
    nbeats = (n == 0) ? 1 : (n + AB - 1) / AB;
    for (int j = 0; j < nbeats; j++) begin
      beat_t b;
      int nb;
      nb = n - AB * j;
      if (nb > AB) nb = AB;
      b.user = user;
      b.last = (j == nbeats - 1);
      b.keep = '0;
      b.data = '0;
      for (int k = 0; k < AB; k++) begin
        if (k < nb) begin
          b.keep[k]        = 1'b1;
          b.data[k*8 +: 8] = 8'(base + AB * j + k);
        end else begin
          b.data[k*8 +: 8] = 8'hEE;
        end
      end
      src.push_back(b);
    end
  endtask

  // One clock: drive at the falling edge, note handshakes, wait for next falling edge.
  task automatic cycle();
    word_t w;
    if (src.size() > 0) begin
      s_tvalid = 1'b1;
      s_tdata  = src[0].data;
      s_tkeep  = src[0].keep;
      s_tuser  = src[0].user;
      s_tlast  = src[0].last;
    end else begin
      s_tvalid = 1'b0;
      s_tdata  = '0;
      s_tkeep  = '0;
      s_tuser  = '0;
      s_tlast  = 1'b0;
    end
    m_ready = ready_toggle ? tog : 1'b1;
    tog = ~tog;
    if (stall_prev && !reset) begin
      check("stall valid", m_valid, 1'b1);
      check("stall data", m_data, sv_data);
      check("stall bytes", m_bytes, sv_bytes);
      check("stall hdr", m_hdr, sv_hdr);
      check("stall last", m_last, sv_last);
    end
    if (m_valid && m_ready && !reset) begin
      w.data  = m_data;
      w.hdr   = m_hdr;
      w.last  = m_last;
      w.bytes = m_bytes;
      w.queue = m_queue;
      w.cyc   = cyc;
      got.push_back(w);
    end
    if (s_tvalid && s_tready && !reset) begin
      void'(src.pop_front());
      in_cnt++;
    end
    stall_prev = m_valid && !m_ready && !reset;
    if (stall_prev) stalls++;
    sv_data  = m_data;
    sv_bytes = m_bytes;
    sv_hdr   = m_hdr;
    sv_last  = m_last;
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_words(input string tag, input int n, input int budget);
    int c;
    c = 0;
    while (got.size() < n && c < budget) begin
      cycle();
      c++;
    end
    if (got.size() < n) check({tag, " timeout"}, got.size(), n);
  endtask

  task automatic expect_pkt(input string tag, input logic [127:0] user, input logic [4:0] q,
                            input int n, input int base, output int hdr_cyc, output int last_cyc);
    word_t        w;
    logic [191:0] ed;
    int           nw, nb;
    nw = (n == 0) ? 1 : (n + MB - 1) / MB;
    hdr_cyc  = -1;
    last_cyc = -1;
    if (got.size() == 0) begin
      check({tag, " hdr present"}, 0, 1);
      return;
    end
    w = got.pop_front();
    hdr_cyc = w.cyc;
    check({tag, " hdr flag"}, w.hdr, 1'b1);
    check({tag, " hdr data"}, w.data, {64'b0, user});
    check({tag, " hdr bytes"}, w.bytes, 5'd24);
    check({tag, " hdr last"}, w.last, 1'b0);
    check({tag, " hdr queue"}, w.queue, q);
    for (int i = 0; i < nw; i++) begin
      if (got.size() == 0) begin
        check($sformatf("%s w%0d present", tag, i), 0, 1);
        return;
      end
      w = got.pop_front();
      nb = n - MB * i;
      if (nb > MB) nb = MB;
      ed = '0;
      for (int k = 0; k < nb; k++) ed[k*8 +: 8] = 8'(base + MB * i + k);
      check($sformatf("%s w%0d data", tag, i), w.data, ed);
      check($sformatf("%s w%0d hdr", tag, i), w.hdr, 1'b0);
      check($sformatf("%s w%0d last", tag, i), w.last, (i == nw - 1));
      check($sformatf("%s w%0d bytes", tag, i), w.bytes, nb);
      check($sformatf("%s w%0d queue", tag, i), w.queue, q);
      last_cyc = w.cyc;
    end
  endtask

  initial begin
    logic [127:0] user_a, user_b, user_c, user_d, user_e, user_f, user_g;
    int start, h1, l1, h2, l2, c;
    user_a = {64'hDEAD_BEEF_0123_4567, 32'h89AB_CDEF, 32'h0400_00A1};
    user_b = {64'h1111_2222_3333_4444, 32'h5555_6666, 32'h0200_00B2};
    user_c = {64'hCAFE_F00D_0000_0001, 32'h0000_0002, 32'h1100_00C3};
    user_d = {96'h0, 32'h0800_0000};
    user_e = {64'h0BAD_CAFE_0000_0000, 32'h0, 32'h4000_00E5};
    user_f = {96'h1, 32'h0100_00F6};
    user_g = {96'h2, 32'h8000_0077};
    n_checks = 0; n_pass = 0; cyc = 0; in_cnt = 0; stalls = 0;
    ready_toggle = 1'b0; tog = 1'b1; stall_prev = 1'b0;
    reset = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tuser = '0; s_tlast = 1'b0;
    m_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst s_tready", s_tready, 1'b0);
    check("rst m_valid", m_valid, 1'b0);
    check("rst m_hdr", m_hdr, 1'b0);
    check("rst m_last", m_last, 1'b0);
    check("rst m_bytes", m_bytes, 5'd0);
    check("rst m_queue", m_queue, 5'd0);
    check("rst m_data", m_data, 192'd0);
    reset = 1'b0;
    repeat (2) cycle();

    // 64-byte packet, two full beats
    send_pkt(user_a, 64, 0);
    start = cyc;
    run_words("t1", 4, 200);
    expect_pkt("t1", user_a, 5'b00010, 64, 0, h1, l1);
    check("t1 hdr latency", h1 - start, 1);

    // single partial beat, tkeep = 0000FFFF
    send_pkt(user_b, 16, 8'h40);
    run_words("t2", 2, 200);
    expect_pkt("t2", user_b, 5'b10000, 16, 8'h40, h1, l1);

    // 96-byte packet under toggling m_ready
    ready_toggle = 1'b1; tog = 1'b1; stalls = 0;
    send_pkt(user_c, 96, 0);
    run_words("t3", 5, 400);
    expect_pkt("t3", user_c, 5'b00101, 96, 0, h1, l1);
    check("t3 stalls seen", (stalls > 0), 1'b1);
    ready_toggle = 1'b0;
    repeat (2) cycle();
    check("t3 extra words", got.size(), 0);

    // reset one cycle after the second beat is accepted
    in_cnt = 0;
    send_pkt(user_d, 96, 8'h20);
    c = 0;
    while (in_cnt < 2 && c < 100) begin
      cycle();
      c++;
    end
    if (in_cnt < 2) check("t4 beat wait timeout", in_cnt, 2);
    src.delete();
    reset = 1'b1;
    cycle();
    check("t4 m_valid", m_valid, 1'b0);
    check("t4 s_tready", s_tready, 1'b0);
    check("t4 m_queue", m_queue, 5'd0);
    check("t4 m_data", m_data, 192'd0);
    reset = 1'b0;
    got.delete();
    stall_prev = 1'b0;
    repeat (2) cycle();
    send_pkt(user_e, 32, 8'h90);
    run_words("t4", 3, 200);
    expect_pkt("t4", user_e, 5'b01000, 32, 8'h90, h1, l1);

    // back-to-back 40-byte packets with s_tvalid held high
    repeat (2) cycle();
    send_pkt(user_f, 40, 8'h10);
    send_pkt(user_g, 40, 8'h80);
    run_words("t5", 6, 300);
    expect_pkt("t5p1", user_f, 5'b00001, 40, 8'h10, h1, l1);
    expect_pkt("t5p2", user_g, 5'b10000, 40, 8'h80, h2, l2);
    check("t5 gap", h2 - l1, 2);

    repeat (5) cycle();
    check("end extra words", got.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_mem_word_packer.md
Name: axis_mem_word_packer

Overview:
- Parametrised successor to the SRAM output-queue ingress converter.
- Repacks a single-clock AXI4-Stream packet of AXIS_DATA_W-bit beats into a stream of MEM_DATA_W-bit memory words for the SRAM write path.
- Emits one header word per packet carrying tuser, then byte-packed payload words, with a last-word byte count and a one-hot destination-queue vector.
- Supports arbitrary byte-multiple width ratios, tkeep-based partial last beats and full ready/valid backpressure on both sides.

Parameters:
AXIS_DATA_W, 256, input tdata width in bits (multiple of 8)
AXIS_USER_W, 128, tuser width in bits (must be <= MEM_DATA_W)
MEM_DATA_W, 192, output memory word width in bits (multiple of 8)
NUM_PORTS, 4, physical ports encoded in tuser destination field
NUM_QUEUES, NUM_PORTS+1, output queues (last index = CPU queue)
DST_POS, 24, bit offset of 2*NUM_PORTS-bit destination field in tuser

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
s_tvalid  in  1  AXIS beat valid
s_tready  out  1  AXIS beat accepted when high with s_tvalid
s_tdata  in  AXIS_DATA_W  payload, byte 0 at bits [7:0]
s_tkeep  in  AXIS_DATA_W/8  byte enables, contiguous from LSB
s_tuser  in  AXIS_USER_W  metadata, sampled on first beat of packet
s_tlast  in  1  last beat of packet
m_valid  out  1  memory word valid
m_ready  in  1  downstream accepts word
m_data  out  MEM_DATA_W  memory word
m_hdr  out  1  word is packet header
m_last  out  1  final payload word of packet
m_bytes  out  clog2(MEM_DATA_W/8+1)  valid bytes in word (full count unless m_last)
m_queue  out  NUM_QUEUES  one-hot/multicast destination, held for whole packet

Behaviour:
- Constants: AB = AXIS_DATA_W/8, MB = MEM_DATA_W/8. Accumulator is AB+MB bytes wide with byte counter acc_bytes.
- Reset: state IDLE, acc_bytes=0; s_tready=0, m_valid=0, m_hdr=0, m_last=0, m_bytes=0, m_queue=0, m_data=0.
- Reset mid-packet discards all buffered data. Outputs reach reset values the cycle after reset is sampled.
- IDLE:
  - s_tready=0, m_valid=0.
  - On s_tvalid: latch s_tuser and m_queue, go to HDR. The beat itself is not consumed.
- HDR:
  - m_valid=1, m_hdr=1, m_data = tuser zero-extended to MEM_DATA_W, m_bytes=MB, s_tready=0.
  - On m_ready, go to DATA.
- DATA:
  - s_tready = (acc_bytes <= MB). This is a registered condition; there is no combinational path from m_ready to s_tready.
  - m_valid = (acc_bytes >= MB), m_data = accumulator bytes [MB-1:0], m_bytes=MB, m_last=0.
  - Pop (m_valid & m_ready) shifts the accumulator down MB bytes.
  - Accepted beat bytes (popcount s_tkeep) are written starting at byte offset acc_bytes minus MB if pop occurred.
  - Pop and accept in the same cycle are legal.
  - Accepting a beat with s_tlast goes to DRAIN.
- DRAIN:
  - s_tready=0, m_valid = 1.
  - m_last = (acc_bytes <= MB); m_bytes = m_last ? acc_bytes : MB.
  - On handshake of the m_last word, go to IDLE and clear acc_bytes.
  - acc_bytes=0 on entry (tlast beat with tkeep=0) produces one m_last word with m_bytes=0.
- Queue decode: even bits tuser[DST_POS+2i] set m_queue[i] for i<NUM_PORTS. OR of all odd bits tuser[DST_POS+2i+1] sets m_queue[NUM_QUEUES-1]. Multiple bits set means multicast.
- m_data, m_bytes, m_hdr and m_last stay stable while m_valid=1 and m_ready=0.
- Latency: first tvalid to header m_valid is 1 cycle. The packet-to-packet gap is 1 IDLE cycle.
- Sustained input throughput is bounded by MB/AB beats per cycle. This is intended.
- Non-contiguous tkeep is undefined and is flagged only by an assertion.

Decomposition:
- Shared package:
  - state enum {IDLE, HDR, DATA, DRAIN};
  - width helpers (bytes-of, clog2);
  - the destination-field decode function, reused by the output-queue arbiter.
- One sub-module: axis_keep_popcount, which counts contiguous tkeep bytes (parametrised width, combinational).

Test Plan:
- 64-byte packet, 2 full beats, bytes 0..63, m_ready=1 -> header word, then payload words with bytes 0-23, 24-47 and 48-63; m_last on the 4th word with m_bytes=16.
- 1 beat with tkeep=32'h0000FFFF and tlast -> header, then one word with m_last=1, m_bytes=16, m_data[127:0]=bytes 0-15.
- tuser destination bits: only bit 26 -> m_queue=5'b00010; only bit 25 -> 5'b10000; bits 24 and 28 -> 5'b00101. Held stable through the last word.
- 96-byte, 3-beat packet with m_ready toggling 1,0,1,0 -> exactly 4 payload words, in-order bytes 0..95, final m_bytes=24, outputs stable during stalls.
- Reset asserted one cycle after 2nd beat accepted -> next cycle m_valid=0, s_tready=0, m_queue=0; following 32-byte packet yields header plus 2 words (24, then 8 with m_last) with no stale data.
- Two back-to-back 40-byte packets with s_tvalid held high -> header of packet 2 appears 2 cycles after packet 1's last-word handshake; no byte mixing between packets.
